// File: rtl/herculesae_vx_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : herculesae_vx_aes_pkg
// Description : Shared AES datapath types and constants. Provides the state
//               width, the 128-bit state type and the sequencing FSM states
//               used by the multi-cycle SubBytes engines.
// Revision    : 1.0  initial release
// ============================================================================
package herculesae_vx_aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aese_seq_state_e;

endpackage : herculesae_vx_aes_pkg
`default_nettype wire

// File: rtl/herculesae_vx_aessbox.sv
`default_nettype none
// ============================================================================
// Module      : herculesae_vx_aessbox
// Description : Combinational 8-bit forward AES S-box.
//               lut_in  [7:0] : byte to substitute
//               lut_out [7:0] : SBOX(lut_in)
// Revision    : 1.0  initial release
// ============================================================================
module herculesae_vx_aessbox (
    input  logic [7:0] lut_in,
    output logic [7:0] lut_out
);

    // Table written in natural order: entry 0 sits in the top byte, so the
    // byte for input x lives at bit offset (255 - x) * 8 = {~x, 3'b000}.
    localparam logic [2047:0] c_SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_bit_ofs;

    assign w_bit_ofs = {~lut_in, 3'b000};
    assign lut_out   = c_SBOX_TBL[w_bit_ofs +: 8];

endmodule : herculesae_vx_aessbox
`default_nettype wire

// File: rtl/herculesae_vx_aese_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : herculesae_vx_aese_sub_seq
// Description : Multi-cycle forward AES SubBytes engine (encrypt path).
//               Substitutes BYTES_PER_CYCLE bytes per cycle through a shared
//               bank of S-boxes, LSB chunk first; byte positions preserved.
//   clk       : core clock, rising edge
//   reset     : synchronous active-high reset
//   flush     : synchronous abort of the in-flight block
//   in_valid  / in_ready  / in_data  [127:0] : block input handshake
//   out_valid / out_ready / out_data [127:0] : result handshake
//   busy      : high while a block is in BUSY or DONE
// Revision    : 1.0  initial release
// ============================================================================
module herculesae_vx_aese_sub_seq
    import herculesae_vx_aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CHUNK_W    = BYTES_PER_CYCLE * 8;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    aese_seq_state_e     r_state;
    logic [CNT_W-1:0]    r_cnt;
    aes_state_t          r_src;
    aes_state_t          r_res;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [CHUNK_W-1:0]  w_chunk;
    logic [CHUNK_W-1:0]  w_sub;

    // Chunk selector feeding the shared S-box bank.
    always_comb begin
        w_chunk = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (r_cnt == CNT_W'(c)) begin
                w_chunk = r_src[c*CHUNK_W +: CHUNK_W];
            end
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        herculesae_vx_aessbox u_sbox (
            .lut_in  (w_chunk[g*8 +: 8]),
            .lut_out (w_sub[g*8 +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_src       <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            // Abort keeps the result register; only control state returns.
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= BUSY;
                        r_src      <= in_data;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int c = 0; c < NUM_CHUNKS; c++) begin
                        if (r_cnt == CNT_W'(c)) begin
                            r_res[c*CHUNK_W +: CHUNK_W] <= w_sub;
                        end
                    end
                    if (r_cnt == c_LAST_CNT) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Ready is held low for as long as reset is asserted, and is already
    // high in the first cycle after it drops.
    assign in_ready  = r_in_ready & ~reset;
    assign out_valid = r_out_valid;
    assign out_data  = r_res;
    assign busy      = r_busy;

endmodule : herculesae_vx_aese_sub_seq
`default_nettype wire

// File: tb/tb_herculesae_vx_aese_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_herculesae_vx_aese_sub_seq
// Description : Self-checking bench for the forward SubBytes engine. Three
//               instances (4, 8, 16 bytes per cycle) share clock, reset and
//               flush; the directed sequences run on the 4-byte instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_herculesae_vx_aese_sub_seq;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [127:0] in_data  [3];
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [127:0] out_data [3];
    logic [2:0]   busy;

    int n_checks = 0;
    int n_err    = 0;
    int acc_cnt [3] = '{0, 0, 0};
    int cmp_cnt [3] = '{0, 0, 0};

    logic [7:0] m_sbox [256];
    logic [7:0] m_inv  [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        herculesae_vx_aese_sub_seq #(
            .BYTES_PER_CYCLE (4 << g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && !flush) begin
            for (int i = 0; i < 3; i++) begin
                if (in_valid[i] && in_ready[i])   acc_cnt[i] <= acc_cnt[i] + 1;
                if (out_valid[i] && out_ready[i]) cmp_cnt[i] <= cmp_cnt[i] + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (GF(2^8) inverse + affine) ----------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            m_sbox[a] = s;
            m_inv[s]  = 8'(a);
        end
    endtask

    function automatic logic [127:0] sub_model(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = m_sbox[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = m_inv[d[8*k +: 8]];
        return r;
    endfunction

    // ---------------- helpers ---------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_out_valid(input int idx, inout int lat);
        while (!out_valid[idx] && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid[idx]) begin
            n_checks++;
            n_err++;
            $display("FAIL out_valid_timeout: inst %0d got no out_valid", idx);
        end
    endtask

    // Offers one block, returns the result and the accept-to-valid latency,
    // then completes the output handshake.
    task automatic run_block(input int idx, input logic [127:0] din,
                             output logic [127:0] dout, output int lat);
        int t;
        in_data[idx]   = din;
        in_valid[idx]  = 1'b1;
        out_ready[idx] = 1'b1;
        t = 0;
        while (!in_ready[idx] && t < 50) begin
            step();
            t++;
        end
        if (!in_ready[idx]) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: inst %0d in_ready never high", idx);
        end
        step();
        in_valid[idx] = 1'b0;
        in_data[idx]  = '0;
        lat = 1;
        wait_out_valid(idx, lat);
        dout = out_data[idx];
        step();
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] res, held, din2;
    int           lat, a0, c0, seen;

    initial begin
        vecs[0] = '{128'h0, 128'h63636363_63636363_63636363_63636363};
        vecs[1] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    128'h76ABD7FE_2B670130_C56F6BF2_7B777C63};
        vecs[2] = '{128'h00112233_44556677_8899AABB_CCDDEEFF,
                    128'h638293C3_1BFC33F5_C4EEACEA_4BC12816};
        vecs[3] = '{{16{8'hFF}}, {16{8'h16}}};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        build_model();

        // ---- reset state ----
        step(); step(); step();
        chk("reset_in_ready",  {127'b0, in_ready[0]},  128'd0);
        chk("reset_out_valid", {125'b0, out_valid},    128'd0);
        chk("reset_busy",      {125'b0, busy},         128'd0);
        chk("reset_out_data",  out_data[0],            128'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", {125'b0, in_ready}, 128'd7);

        // ---- directed vectors ----
        for (int v = 0; v < 4; v++) begin
            run_block(0, vecs[v].din, res, lat);
            chk($sformatf("vec%0d_data", v), res, vecs[v].dout);
            chk($sformatf("vec%0d_latency", v), 128'(lat), 128'd5);
            chk($sformatf("vec%0d_ready_after", v), {127'b0, in_ready[0]}, 128'd1);
            if (v == 1) chk("vec1_inverse", inv_model(res), vecs[v].din);
        end

        // ---- output stall: 20 cycles with out_ready low ----
        in_data[0]   = 128'h3243F6A8_885A308D_313198A2_E0370734;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        step();
        in_valid[0] = 1'b0;
        lat = 1;
        wait_out_valid(0, lat);
        held = sub_model(in_data[0]);
        a0   = acc_cnt[0];
        din2 = 128'hDEADBEEF_01234567_89ABCDEF_C0FFEE00;
        in_data[0]  = din2;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stall_out_valid", {127'b0, out_valid[0]}, 128'd1);
            chk("stall_out_data",  out_data[0],            held);
            chk("stall_in_ready",  {127'b0, in_ready[0]},  128'd0);
        end
        chk("stall_no_accept", 128'(acc_cnt[0]), 128'(a0));
        out_ready[0] = 1'b1;
        step();
        chk("release_out_valid", {127'b0, out_valid[0]}, 128'd0);
        chk("release_in_ready",  {127'b0, in_ready[0]},  128'd1);
        step();
        in_valid[0] = 1'b0;
        chk("release_accept", 128'(acc_cnt[0]), 128'(a0 + 1));
        lat = 1;
        wait_out_valid(0, lat);
        chk("release_second_data", out_data[0], sub_model(din2));
        chk("release_second_latency", 128'(lat), 128'd5);
        step();

        // ---- flush in cycle 2 of BUSY ----
        in_data[0]  = 128'h11111111_22222222_33333333_44444444;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle_in_ready", {127'b0, in_ready[0]}, 128'd1);
        chk("flush_idle_busy",     {127'b0, busy[0]},     128'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[0]) seen++;
            step();
        end
        chk("flush_no_out_valid", 128'(seen), 128'd0);

        // flush in IDLE together with in_valid: no accept
        a0 = acc_cnt[0];
        flush       = 1'b1;
        in_valid[0] = 1'b1;
        step();
        flush       = 1'b0;
        in_valid[0] = 1'b0;
        chk("flush_idle_no_busy",  {127'b0, busy[0]},     128'd0);
        chk("flush_idle_ready",    {127'b0, in_ready[0]}, 128'd1);

        run_block(0, {16{8'hFF}}, res, lat);
        chk("post_flush_data", res, {16{8'h16}});

        // flush in DONE: result dropped but result register kept
        in_data[0]   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        step();
        in_valid[0] = 1'b0;
        lat = 1;
        wait_out_valid(0, lat);
        held = sub_model(in_data[0]);
        flush        = 1'b1;
        out_ready[0] = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_out_valid", {127'b0, out_valid[0]}, 128'd0);
        chk("flush_done_keep_data", out_data[0],            held);

        // ---- reset asserted in DONE with out_ready low ----
        in_data[0]   = 128'h0102030405060708090A0B0C0D0E0F10;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        step();
        in_valid[0] = 1'b0;
        lat = 1;
        wait_out_valid(0, lat);
        reset = 1'b1;
        step();
        chk("rst_done_out_valid", {127'b0, out_valid[0]}, 128'd0);
        chk("rst_done_out_data",  out_data[0],            128'd0);
        chk("rst_done_in_ready",  {127'b0, in_ready[0]},  128'd0);
        reset = 1'b0;
        #1;
        chk("rst_done_ready_after", {127'b0, in_ready[0]}, 128'd1);
        step();

        // ---- random sweep across all three widths ----
        for (int idx = 0; idx < 3; idx++) begin
            a0 = acc_cnt[idx];
            c0 = cmp_cnt[idx];
            for (int n = 0; n < 1000; n++) begin
                din2 = {$urandom, $urandom, $urandom, $urandom};
                run_block(idx, din2, res, lat);
                chk($sformatf("rand%0d_data", idx), res, sub_model(din2));
                chk($sformatf("rand%0d_latency", idx), 128'(lat), 128'((4 >> idx) + 1));
            end
            step();
            chk($sformatf("rand%0d_accepts", idx),   128'(acc_cnt[idx] - a0), 128'd1000);
            chk($sformatf("rand%0d_completes", idx), 128'(cmp_cnt[idx] - c0), 128'd1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_herculesae_vx_aese_sub_seq
`default_nettype wire
